// File: rtl/btb_upd_ctrl.sv
// BTB training-update scheduler: buffers up to two commits per cycle, drains one per
// cycle onto the training port, and runs a full-table invalidate sweep on flush.
module btb_upd_ctrl #(
    parameter int ADDR     = 32,
    parameter int BTB_D    = 512,
    parameter int QDEPTH   = 4,
    parameter int INST_OFS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               com_valid_,
    input  logic [1:0]               com_br_,
    input  logic [1:0]               com_taken_,
    input  logic [1:0]               com_miss_,
    input  logic [2*ADDR-1:0]        com_addr,
    input  logic [2*ADDR-1:0]        com_tar,
    output logic                     com_stall,
    input  logic                     flush_req_,
    output logic                     flush_busy,
    output logic                     flush_done,
    output logic                     br_commit_,
    output logic                     br_taken_,
    output logic                     br_miss_,
    output logic                     jump_commit_,
    output logic                     jump_miss_,
    output logic [ADDR-1:0]          btb_com_addr,
    output logic [ADDR-1:0]          btb_com_tar,
    output logic                     btb_inv_,
    output logic [$clog2(BTB_D)-1:0] btb_inv_idx,
    output logic                     pred_block_
);

    localparam int IW = $clog2(BTB_D);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] STALL_TH   = CW'(QDEPTH - 2);
    localparam logic [IW-1:0] SWEEP_LAST = IW'(BTB_D - 1);

    if (QDEPTH < 2 || (1 << PW) != QDEPTH || (1 << IW) != BTB_D || INST_OFS >= ADDR) begin : g_param_check
        $error("btb_upd_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr, wr_ptr, wr_ptr_s1;
    logic [IW-1:0]   sweep_cnt;
    logic            flush_acc, drain, enq0, enq1;
    logic [1:0]      n_enq;

    logic            q_br    [QDEPTH];
    logic            q_taken [QDEPTH];
    logic            q_miss  [QDEPTH];
    logic [ADDR-1:0] q_addr  [QDEPTH];
    logic [ADDR-1:0] q_tar   [QDEPTH];

    assign flush_acc = (state == IDLE) && !flush_req_;
    assign com_stall = (state != IDLE) || (count > STALL_TH) || !flush_req_;
    assign drain     = (state == IDLE) && (count != '0) && flush_req_;
    assign enq0      = !com_stall && !com_valid_[0];
    assign enq1      = !com_stall && !com_valid_[1];
    assign n_enq     = {1'b0, enq0} + {1'b0, enq1};
    // Slot 1 lands right behind slot 0 only when slot 0 was actually written.
    assign wr_ptr_s1 = enq0 ? wr_ptr + PW'(1) : wr_ptr;

    always_ff @(posedge clk) begin
        if (enq0) begin
            q_br[wr_ptr]    <= com_br_[0];
            q_taken[wr_ptr] <= com_taken_[0];
            q_miss[wr_ptr]  <= com_miss_[0];
            q_addr[wr_ptr]  <= com_addr[ADDR-1:0];
            q_tar[wr_ptr]   <= com_tar[ADDR-1:0];
        end
        if (enq1) begin
            q_br[wr_ptr_s1]    <= com_br_[1];
            q_taken[wr_ptr_s1] <= com_taken_[1];
            q_miss[wr_ptr_s1]  <= com_miss_[1];
            q_addr[wr_ptr_s1]  <= com_addr[2*ADDR-1:ADDR];
            q_tar[wr_ptr_s1]   <= com_tar[2*ADDR-1:ADDR];
        end
    end

    // Accepting a flush discards the queue: those updates would be invalidated anyway.
    always_ff @(posedge clk) begin
        if (reset || flush_acc) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + CW'(n_enq) - CW'(drain);
            rd_ptr <= rd_ptr + PW'(drain);
            wr_ptr <= wr_ptr + PW'(n_enq);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_acc)
            sweep_cnt <= '0;
        else if (state == SWEEP)
            sweep_cnt <= sweep_cnt + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!flush_req_) state_next = SWEEP;
            SWEEP:   if (sweep_cnt == SWEEP_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Prediction is blocked already in the accept cycle so no stale hit slips through.
    always_comb begin
        br_commit_   = 1'b1;
        br_taken_    = 1'b1;
        br_miss_     = 1'b1;
        jump_commit_ = 1'b1;
        jump_miss_   = 1'b1;
        btb_com_addr = '0;
        btb_com_tar  = '0;
        btb_inv_     = 1'b1;
        btb_inv_idx  = '0;
        flush_done   = 1'b0;
        flush_busy   = 1'b0;
        pred_block_  = 1'b1;
        case (state)
            IDLE: begin
                if (flush_acc) begin
                    pred_block_ = 1'b0;
                end else if (drain) begin
                    btb_com_addr = q_addr[rd_ptr];
                    btb_com_tar  = q_tar[rd_ptr];
                    if (q_br[rd_ptr]) begin
                        jump_commit_ = 1'b0;
                        jump_miss_   = q_miss[rd_ptr];
                    end else begin
                        br_commit_ = 1'b0;
                        br_taken_  = q_taken[rd_ptr];
                        br_miss_   = q_miss[rd_ptr];
                    end
                end
            end
            SWEEP: begin
                flush_busy  = 1'b1;
                pred_block_ = 1'b0;
                btb_inv_    = 1'b0;
                btb_inv_idx = sweep_cnt;
            end
            DONE: begin
                flush_busy  = 1'b1;
                pred_block_ = 1'b0;
                flush_done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_btb_upd_ctrl.sv
// Self-checking bench for btb_upd_ctrl: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_btb_upd_ctrl;

    localparam int ADDR   = 32;
    localparam int BTB_D  = 512;
    localparam int QDEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        com_valid_ = 2'b11;
    logic [1:0]        com_br_ = 2'b00;
    logic [1:0]        com_taken_ = 2'b11;
    logic [1:0]        com_miss_ = 2'b11;
    logic [2*ADDR-1:0] com_addr = '0;
    logic [2*ADDR-1:0] com_tar = '0;
    logic              com_stall;
    logic              flush_req_ = 1'b1;
    logic              flush_busy, flush_done;
    logic              br_commit_, br_taken_, br_miss_, jump_commit_, jump_miss_;
    logic [ADDR-1:0]   btb_com_addr, btb_com_tar;
    logic              btb_inv_;
    logic [8:0]        btb_inv_idx;
    logic              pred_block_;

    btb_upd_ctrl #(.ADDR(ADDR), .BTB_D(BTB_D), .QDEPTH(QDEPTH), .INST_OFS(2)) dut (
        .clk(clk), .reset(reset),
        .com_valid_(com_valid_), .com_br_(com_br_), .com_taken_(com_taken_), .com_miss_(com_miss_),
        .com_addr(com_addr), .com_tar(com_tar), .com_stall(com_stall),
        .flush_req_(flush_req_), .flush_busy(flush_busy), .flush_done(flush_done),
        .br_commit_(br_commit_), .br_taken_(br_taken_), .br_miss_(br_miss_),
        .jump_commit_(jump_commit_), .jump_miss_(jump_miss_),
        .btb_com_addr(btb_com_addr), .btb_com_tar(btb_com_tar),
        .btb_inv_(btb_inv_), .btb_inv_idx(btb_inv_idx), .pred_block_(pred_block_)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic        tk;
        logic        ms;
        logic [31:0] a;
        logic [31:0] t;
    } entry_t;

    // Model: mode 0 = idle, 1 = sweeping, 2 = done pulse.
    entry_t q[$];
    int     mode = 0;
    int     sweepIdx = 0;
    bit     modelValid = 0;
    int     compared = 0;
    int     mismatched = 0;
    int     doneSeen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] br, input logic [1:0] tk,
                                 input logic [1:0] ms, input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] t0, input logic [31:0] t1, input logic fl);
        com_valid_ = v;
        com_br_    = br;
        com_taken_ = tk;
        com_miss_  = ms;
        com_addr   = {a1, a0};
        com_tar    = {t1, t0};
        flush_req_ = fl;
    endtask

    task automatic applyIdle();
        applyStimulus(2'b11, 2'b00, 2'b11, 2'b11, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    endtask

    function automatic bit expStall();
        return (mode != 0) || (q.size() > QDEPTH - 2) || (flush_req_ == 1'b0);
    endfunction

    task automatic checkOutput();
        bit          accept;
        bit          drain;
        entry_t      h;
        logic        ebc, ebt, ebm, ejc, ejm;
        logic [31:0] ea, et;
        if (flush_done === 1'b1) doneSeen++;
        if (!modelValid) return;
        accept = (mode == 0) && (flush_req_ == 1'b0);
        drain  = (mode == 0) && (q.size() > 0) && (flush_req_ == 1'b1);
        ebc = 1; ebt = 1; ebm = 1; ejc = 1; ejm = 1; ea = 0; et = 0;
        if (drain) begin
            h  = q[0];
            ea = h.a;
            et = h.t;
            if (h.br) begin
                ejc = 0; ejm = h.ms;
            end else begin
                ebc = 0; ebt = h.tk; ebm = h.ms;
            end
        end
        chk("com_stall", com_stall, expStall());
        chk("br_commit_", br_commit_, ebc);
        chk("br_taken_", br_taken_, ebt);
        chk("br_miss_", br_miss_, ebm);
        chk("jump_commit_", jump_commit_, ejc);
        chk("jump_miss_", jump_miss_, ejm);
        chk("btb_com_addr", btb_com_addr, ea);
        chk("btb_com_tar", btb_com_tar, et);
        chk("pred_block_", pred_block_, !((mode != 0) || accept));
        chk("flush_busy", flush_busy, mode != 0);
        chk("flush_done", flush_done, mode == 2);
        chk("btb_inv_", btb_inv_, mode != 1);
        chk("btb_inv_idx", btb_inv_idx, (mode == 1) ? sweepIdx : 0);
    endtask

    task automatic modelStep();
        bit st;
        if (reset) begin
            mode = 0; sweepIdx = 0; q.delete(); modelValid = 1;
            return;
        end
        if (!modelValid) return;
        case (mode)
            0: begin
                if (!flush_req_) begin
                    q.delete(); mode = 1; sweepIdx = 0;
                end else begin
                    st = expStall();
                    if (q.size() > 0) void'(q.pop_front());
                    if (!st && !com_valid_[0])
                        q.push_back('{com_br_[0], com_taken_[0], com_miss_[0], com_addr[31:0], com_tar[31:0]});
                    if (!st && !com_valid_[1])
                        q.push_back('{com_br_[1], com_taken_[1], com_miss_[1], com_addr[63:32], com_tar[63:32]});
                end
            end
            1: if (sweepIdx == BTB_D - 1) mode = 2; else sweepIdx++;
            default: mode = 0;
        endcase
    endtask

    task automatic stepCycle();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic dualPair(input logic [31:0] base);
        applyStimulus(2'b00, 2'b10, 2'b10, 2'b01, base, base + 32'h4, base + 32'h40, base + 32'h80, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        bit st;
        bit accepted;

        // Reset and idle.
        applyIdle();
        reset = 1'b1;
        stepCycle();
        stepCycle();
        reset = 1'b0;
        #1;
        chk("rst_stall", com_stall, 0);
        chk("rst_busy", flush_busy, 0);
        chk("rst_br_commit", br_commit_, 1);
        chk("rst_jump_commit", jump_commit_, 1);
        chk("rst_inv", btb_inv_, 1);
        chk("rst_pblk", pred_block_, 1);
        chk("rst_addr", btb_com_addr, 0);
        stepCycle();

        // Branch (taken, no miss) + jump (target miss) in one cycle.
        applyStimulus(2'b00, 2'b10, 2'b10, 2'b01, 32'h100, 32'h200, 32'h140, 32'h300, 1'b1);
        stepCycle();
        applyIdle();
        #1;
        chk("d1_br_commit", br_commit_, 0);
        chk("d1_br_taken", br_taken_, 0);
        chk("d1_br_miss", br_miss_, 1);
        chk("d1_addr", btb_com_addr, 32'h100);
        chk("d1_tar", btb_com_tar, 32'h140);
        stepCycle();
        chk("d2_jump_commit", jump_commit_, 0);
        chk("d2_jump_miss", jump_miss_, 0);
        chk("d2_br_commit", br_commit_, 1);
        chk("d2_addr", btb_com_addr, 32'h200);
        stepCycle();
        chk("d3_idle_br", br_commit_, 1);
        chk("d3_idle_jump", jump_commit_, 1);
        chk("d3_idle_addr", btb_com_addr, 0);

        // Fill to threshold; third pair is held until accepted; order across wrap.
        dualPair(32'h1000);
        stepCycle();
        dualPair(32'h2000);
        stepCycle();
        dualPair(32'h3000);
        #1;
        chk("fill_stall", com_stall, 1);
        accepted = 0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            st = expStall();
            stepCycle();
            if (!st) accepted = 1;
        end
        chk("fill_accepted", accepted, 1);
        applyIdle();
        for (int i = 0; i < 8; i++) stepCycle();

        // Flush with 3 entries queued.
        dualPair(32'h4000);
        stepCycle();
        dualPair(32'h5000);
        stepCycle();
        applyStimulus(2'b00, 2'b10, 2'b10, 2'b01, 32'h6000, 32'h6004, 32'h0, 32'h0, 1'b0);
        #1;
        chk("acc_stall", com_stall, 1);
        chk("acc_pblk", pred_block_, 0);
        chk("acc_nodrain_br", br_commit_, 1);
        chk("acc_nodrain_jump", jump_commit_, 1);
        stepCycle();
        applyIdle();
        for (int i = 0; i < BTB_D; i++) begin
            chk("sweep_idx", btb_inv_idx, i);
            chk("sweep_inv", btb_inv_, 0);
            stepCycle();
        end
        chk("done_pulse", flush_done, 1);
        chk("done_inv", btb_inv_, 1);
        stepCycle();
        chk("after_busy", flush_busy, 0);
        chk("after_done", flush_done, 0);
        chk("after_no_issue", br_commit_ & jump_commit_, 1);
        for (int i = 0; i < 3; i++) stepCycle();

        // Second flush request mid-sweep is ignored.
        d0 = doneSeen;
        applyStimulus(2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 0, 0, 1'b0);
        stepCycle();
        applyIdle();
        for (int i = 0; i < 200; i++) stepCycle();
        flush_req_ = 1'b0;
        stepCycle();
        applyIdle();
        for (int i = 0; i < 400; i++) stepCycle();
        chk("single_done", doneSeen - d0, 1);
        chk("refl_busy", flush_busy, 0);

        // Reset in the middle of a sweep.
        d0 = doneSeen;
        flush_req_ = 1'b0;
        stepCycle();
        applyIdle();
        for (int i = 0; i < 100; i++) stepCycle();
        chk("mid_idx", btb_inv_idx, 100);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        #1;
        chk("mid_inv", btb_inv_, 1);
        chk("mid_busy", flush_busy, 0);
        chk("mid_done", flush_done, 0);
        applyStimulus(2'b10, 2'b00, 2'b10, 2'b11, 32'h300, 32'h0, 32'h380, 32'h0, 1'b1);
        #1;
        chk("mid_stall", com_stall, 0);
        stepCycle();
        applyIdle();
        #1;
        chk("mid_br_commit", br_commit_, 0);
        chk("mid_addr", btb_com_addr, 32'h300);
        for (int i = 0; i < 600; i++) stepCycle();
        chk("mid_no_done", doneSeen - d0, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                          ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
            reset = ($urandom_range(0, 1999) == 0);
            stepCycle();
        end
        reset = 1'b0;
        applyIdle();
        for (int i = 0; i < 6; i++) stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
